// File: rtl/tree_walk_pkg.sv
// Shared types for the packet-classification tree walker: node layout,
// walker states and the key field selector.
package tree_walk_pkg;

    localparam int NUM_FIELDS = 5;
    localparam int FIELD_W    = 16;
    localparam int NODE_AW    = 10;
    localparam int RULE_W     = 12;
    localparam int SEL_W      = $clog2(NUM_FIELDS);
    localparam int KEY_W      = NUM_FIELDS * FIELD_W;

    typedef enum logic [1:0] {
        NODE_CUT   = 2'b00,
        NODE_PART  = 2'b01,
        NODE_LEAF  = 2'b10,
        NODE_EMPTY = 2'b11
    } node_type_e;

    typedef struct packed {
        node_type_e           node_type;
        logic [SEL_W-1:0]     field_sel;
        logic [FIELD_W-1:0]   a;
        logic [FIELD_W-1:0]   b;
        logic [NODE_AW-1:0]   left;
        logic [NODE_AW-1:0]   right;
        logic [RULE_W-1:0]    rule_id;
    } node_t;

    localparam int NODE_W = $bits(node_t);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EVAL,
        S_POP,
        S_POPWAIT,
        S_DONE
    } state_e;

    // Out-of-range selectors read as zero rather than aliasing another field.
    function automatic logic [FIELD_W-1:0] field_of(input logic [KEY_W-1:0] key,
                                                    input logic [SEL_W-1:0] sel);
        field_of = '0;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            if (sel == SEL_W'(i)) field_of = key[i*FIELD_W +: FIELD_W];
        end
    endfunction

endpackage

// File: rtl/tree_walk_ctrl_stack.sv
// LIFO of pending subtree addresses. Push wins over pop; a pop result
// appears on pop_data together with a one-cycle just_popped pulse.
module stack #(
    parameter int DATA_WIDTH = 10,
    parameter int STACK_SIZE = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  full,
    output logic                  empty,
    output logic                  just_popped
);

    localparam int IDX_W = (STACK_SIZE > 1) ? $clog2(STACK_SIZE) : 1;
    localparam int CNT_W = $clog2(STACK_SIZE + 1);

    logic [DATA_WIDTH-1:0] mem_q [STACK_SIZE];
    logic [CNT_W-1:0]      sp_q, sp_d;
    logic                  just_popped_q, just_popped_d;
    logic [DATA_WIDTH-1:0] pop_data_q, pop_data_d;
    logic                  wr_en;
    logic [IDX_W-1:0]      wr_idx;
    logic [IDX_W-1:0]      rd_idx;

    assign full        = (sp_q == CNT_W'(STACK_SIZE));
    assign empty       = (sp_q == '0);
    assign pop_data    = pop_data_q;
    assign just_popped = just_popped_q;
    assign wr_idx      = IDX_W'(sp_q);
    assign rd_idx      = IDX_W'(sp_q - 1'b1);

    always_comb begin
        sp_d          = sp_q;
        just_popped_d = 1'b0;
        pop_data_d    = pop_data_q;
        wr_en         = 1'b0;
        if (push && !full) begin
            wr_en = 1'b1;
            sp_d  = sp_q + 1'b1;
        end else if (pop && !empty) begin
            pop_data_d    = mem_q[rd_idx];
            sp_d          = sp_q - 1'b1;
            just_popped_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q          <= '0;
            just_popped_q <= 1'b0;
        end else begin
            sp_q          <= sp_d;
            just_popped_q <= just_popped_d;
        end
    end

    always_ff @(posedge clk) begin
        pop_data_q <= pop_data_d;
        if (wr_en) mem_q[wr_idx] <= push_data;
    end

endmodule

// File: rtl/tree_walk_ctrl.sv
// Depth-first decision-tree walker: one key at a time, left-first descent,
// pending right subtrees kept on a LIFO, lowest matching rule id wins.
module tree_walk_ctrl
    import tree_walk_pkg::*;
#(
    parameter int STACK_DEPTH = 32,
    parameter int MAX_STEPS   = 1024,
    parameter int ROOT_ADDR   = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [KEY_W-1:0]   req_key,
    output logic               mem_rd_en,
    output logic [NODE_AW-1:0] mem_addr,
    input  logic [NODE_W-1:0]  mem_rdata,
    output logic               resp_valid,
    output logic               resp_hit,
    output logic [RULE_W-1:0]  resp_rule_id,
    output logic               resp_overflow,
    output logic               resp_timeout
);

    localparam int STEP_W = $clog2(MAX_STEPS + 1);
    localparam logic [STEP_W-1:0] MAX_STEPS_C = STEP_W'(MAX_STEPS);

    state_e              state_q, state_d;
    logic [KEY_W-1:0]    key_q, key_d;
    logic [NODE_AW-1:0]  cur_q, cur_d;
    logic [RULE_W-1:0]   best_q, best_d;
    logic                hit_q, hit_d;
    logic [STEP_W-1:0]   steps_q, steps_d;
    logic                resp_hit_q, resp_hit_d;
    logic [RULE_W-1:0]   resp_rule_id_q, resp_rule_id_d;
    logic                resp_overflow_q, resp_overflow_d;
    logic                resp_timeout_q, resp_timeout_d;

    logic                accept;
    logic                stk_push, stk_pop, stk_reset;
    logic                stk_full, stk_empty, stk_just_popped;
    logic [NODE_AW-1:0]  stk_pop_data;
    node_t               node;
    logic [FIELD_W-1:0]  k;
    logic [STEP_W-1:0]   steps_inc;
    logic                leaf_end;

    assign node      = node_t'(mem_rdata);
    assign k         = field_of(key_q, node.field_sel);
    assign steps_inc = steps_q + 1'b1;
    assign stk_reset = reset || accept;

    assign req_ready     = (state_q == S_IDLE);
    assign mem_addr      = cur_q;
    assign resp_hit      = resp_hit_q;
    assign resp_rule_id  = resp_rule_id_q;
    assign resp_overflow = resp_overflow_q;
    assign resp_timeout  = resp_timeout_q;

    stack #(
        .DATA_WIDTH (NODE_AW),
        .STACK_SIZE (STACK_DEPTH)
    ) u_stack (
        .clk         (clk),
        .reset       (stk_reset),
        .push        (stk_push),
        .pop         (stk_pop),
        .push_data   (node.right),
        .pop_data    (stk_pop_data),
        .full        (stk_full),
        .empty       (stk_empty),
        .just_popped (stk_just_popped)
    );

    always_comb begin
        state_d         = state_q;
        key_d           = key_q;
        cur_d           = cur_q;
        best_d          = best_q;
        hit_d           = hit_q;
        steps_d         = steps_q;
        resp_hit_d      = resp_hit_q;
        resp_rule_id_d  = resp_rule_id_q;
        resp_overflow_d = resp_overflow_q;
        resp_timeout_d  = resp_timeout_q;
        accept          = 1'b0;
        stk_push        = 1'b0;
        stk_pop         = 1'b0;
        mem_rd_en       = 1'b0;
        resp_valid      = 1'b0;
        leaf_end        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    accept          = 1'b1;
                    key_d           = req_key;
                    cur_d           = NODE_AW'(ROOT_ADDR);
                    best_d          = '1;
                    hit_d           = 1'b0;
                    steps_d         = '0;
                    resp_hit_d      = 1'b0;
                    resp_rule_id_d  = '0;
                    resp_overflow_d = 1'b0;
                    resp_timeout_d  = 1'b0;
                    state_d         = S_FETCH;
                end
            end
            S_FETCH: begin
                mem_rd_en = 1'b1;
                state_d   = S_EVAL;
            end
            S_EVAL: begin
                steps_d = steps_inc;
                // The step budget is checked before the node is acted on.
                if (steps_inc >= MAX_STEPS_C) begin
                    resp_timeout_d = 1'b1;
                    resp_hit_d     = 1'b0;
                    resp_rule_id_d = '0;
                    state_d        = S_DONE;
                end else begin
                    case (node.node_type)
                        NODE_CUT: begin
                            cur_d   = (k < node.a) ? node.left : node.right;
                            state_d = S_FETCH;
                        end
                        NODE_PART: begin
                            if (stk_full) begin
                                resp_overflow_d = 1'b1;
                                resp_hit_d      = 1'b0;
                                resp_rule_id_d  = '0;
                                state_d         = S_DONE;
                            end else begin
                                stk_push = 1'b1;
                                cur_d    = node.left;
                                state_d  = S_FETCH;
                            end
                        end
                        NODE_LEAF: begin
                            if ((k >= node.a) && (k <= node.b) && (node.rule_id < best_q)) begin
                                best_d = node.rule_id;
                                hit_d  = 1'b1;
                            end
                            leaf_end = 1'b1;
                        end
                        default: leaf_end = 1'b1;
                    endcase
                    if (leaf_end) begin
                        if (stk_empty) begin
                            resp_hit_d     = hit_d;
                            resp_rule_id_d = hit_d ? best_d : '0;
                            state_d        = S_DONE;
                        end else begin
                            state_d = S_POP;
                        end
                    end
                end
            end
            S_POP: begin
                stk_pop = 1'b1;
                state_d = S_POPWAIT;
            end
            S_POPWAIT: begin
                if (stk_just_popped) begin
                    cur_d   = stk_pop_data;
                    state_d = S_FETCH;
                end
            end
            S_DONE: begin
                resp_valid = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            resp_hit_q      <= 1'b0;
            resp_rule_id_q  <= '0;
            resp_overflow_q <= 1'b0;
            resp_timeout_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            resp_hit_q      <= resp_hit_d;
            resp_rule_id_q  <= resp_rule_id_d;
            resp_overflow_q <= resp_overflow_d;
            resp_timeout_q  <= resp_timeout_d;
        end
    end

    // Walk datapath is reloaded on every accept, so it carries no reset.
    always_ff @(posedge clk) begin
        key_q   <= key_d;
        cur_q   <= cur_d;
        best_q  <= best_d;
        hit_q   <= hit_d;
        steps_q <= steps_d;
    end

endmodule

// File: tb/tb_tree_walk_ctrl.sv
// Directed and randomised walks of tree_walk_ctrl against hand-computed
// results and a sequential DFS model.
module tb_tree_walk_ctrl;
    import tree_walk_pkg::*;

    localparam int SD = 2;
    localparam int MS = 16;

    logic               clk = 1'b0;
    logic               reset;
    logic               req_valid;
    logic               req_ready;
    logic [KEY_W-1:0]   req_key;
    logic               mem_rd_en;
    logic [NODE_AW-1:0] mem_addr;
    logic [NODE_W-1:0]  mem_rdata;
    logic               resp_valid;
    logic               resp_hit;
    logic [RULE_W-1:0]  resp_rule_id;
    logic               resp_overflow;
    logic               resp_timeout;

    node_t nodes [0:1023];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    viol     = 0;
    int    pushes   = 0;
    int    pops     = 0;
    logic  last_empty;

    always #5 clk = ~clk;

    tree_walk_ctrl #(
        .STACK_DEPTH (SD),
        .MAX_STEPS   (MS),
        .ROOT_ADDR   (0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_key       (req_key),
        .mem_rd_en     (mem_rd_en),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .resp_valid    (resp_valid),
        .resp_hit      (resp_hit),
        .resp_rule_id  (resp_rule_id),
        .resp_overflow (resp_overflow),
        .resp_timeout  (resp_timeout)
    );

    always @(posedge clk) if (mem_rd_en) mem_rdata <= nodes[mem_addr];

    always @(negedge clk) begin
        if (!reset) begin
            if (mem_rd_en && (req_ready || resp_valid)) viol++;
            if (dut.stk_push && dut.stk_pop) viol++;
            if (dut.stk_push) pushes++;
            if (dut.stk_pop) pops++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic node_t mk_node(input node_type_e t, input int sel, input int a, input int b,
                                      input int l, input int r, input int rule);
        node_t n;
        n.node_type = t;
        n.field_sel = SEL_W'(sel);
        n.a         = FIELD_W'(a);
        n.b         = FIELD_W'(b);
        n.left      = NODE_AW'(l);
        n.right     = NODE_AW'(r);
        n.rule_id   = RULE_W'(rule);
        return n;
    endfunction

    function automatic logic [KEY_W-1:0] mk_key(input int f0, input int f1, input int f2,
                                                input int f3, input int f4);
        return {FIELD_W'(f4), FIELD_W'(f3), FIELD_W'(f2), FIELD_W'(f1), FIELD_W'(f0)};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) nodes[i] = mk_node(NODE_EMPTY, 0, 0, 0, 0, 0, 0);
    endtask

    // Sequential DFS reference: cycles = 2 per evaluated node + 2 per pop + 1 for DONE.
    task automatic model(input logic [KEY_W-1:0] key, output logic hit, output int rule,
                         output logic ovf, output logic to, output int lat);
        logic [NODE_AW-1:0] stk [SD];
        logic [NODE_AW-1:0] cur;
        logic [RULE_W-1:0]  best;
        logic [FIELD_W-1:0] k;
        node_t n;
        int sp, steps, npop;
        bit done;
        cur = '0; best = '1; hit = 0; ovf = 0; to = 0;
        sp = 0; steps = 0; npop = 0; done = 0;
        while (!done) begin
            n = nodes[cur];
            steps++;
            k = key[n.field_sel*FIELD_W +: FIELD_W];
            if (steps >= MS) begin
                to = 1; done = 1;
            end else if (n.node_type == NODE_CUT) begin
                cur = (k < n.a) ? n.left : n.right;
            end else if (n.node_type == NODE_PART) begin
                if (sp == SD) begin
                    ovf = 1; done = 1;
                end else begin
                    stk[sp] = n.right; sp++; cur = n.left;
                end
            end else begin
                if (n.node_type == NODE_LEAF && k >= n.a && k <= n.b && n.rule_id < best) begin
                    best = n.rule_id; hit = 1;
                end
                if (sp == 0) done = 1;
                else begin
                    sp--; cur = stk[sp]; npop++;
                end
            end
        end
        hit  = hit && !ovf && !to;
        rule = hit ? int'(best) : 0;
        lat  = 2*steps + 2*npop + 1;
    endtask

    task automatic run_walk(input string tag, input logic [KEY_W-1:0] key, input logic eh,
                            input int er, input logic eo, input logic et, input int el);
        int  n;
        bit  got;
        logic [RULE_W-1:0] held;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, ".ready"}, req_ready, 1);
        req_valid = 1'b1;
        req_key   = key;
        @(posedge clk);
        n = 0; got = 0;
        while (!got && n < 300) begin
            @(negedge clk);
            req_valid = 1'b0;
            n++;
            if (resp_valid) got = 1;
        end
        check_eq({tag, ".resp_seen"}, got, 1);
        if (got) begin
            last_empty = dut.stk_empty;
            check_eq({tag, ".hit"}, resp_hit, eh);
            check_eq({tag, ".rule"}, resp_rule_id, er);
            check_eq({tag, ".ovf"}, resp_overflow, eo);
            check_eq({tag, ".tmo"}, resp_timeout, et);
            check_eq({tag, ".lat"}, n, el);
            held = resp_rule_id;
            @(negedge clk);
            check_eq({tag, ".pulse"}, resp_valid, 0);
            check_eq({tag, ".held"}, resp_rule_id, held);
        end
    endtask

    task automatic build_part_tree();
        clear_mem();
        nodes[0] = mk_node(NODE_PART, 0, 0, 0, 1, 2, 0);
        nodes[1] = mk_node(NODE_LEAF, 0, 0, 16'hffff, 0, 0, 5);
        nodes[2] = mk_node(NODE_LEAF, 0, 0, 16'hffff, 0, 0, 2);
    endtask

    initial begin
        logic eh, eo, et;
        int   er, el, p0, q0, seen;
        logic [KEY_W-1:0] key;

        reset = 1'b1; req_valid = 1'b0; req_key = '0;
        clear_mem();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst.ready", req_ready, 1);
        check_eq("rst.rd_en", mem_rd_en, 0);
        check_eq("rst.valid", resp_valid, 0);
        check_eq("rst.hit", resp_hit, 0);
        check_eq("rst.rule", resp_rule_id, 0);
        check_eq("rst.ovf", resp_overflow, 0);
        check_eq("rst.tmo", resp_timeout, 0);
        reset = 1'b0;

        // Root leaf: inside, lower bound inclusive, just above upper bound
        nodes[0] = mk_node(NODE_LEAF, 0, 10, 20, 0, 0, 7);
        run_walk("t1_in", mk_key(15, 0, 0, 0, 0), 1, 7, 0, 0, 3);
        run_walk("t1_lo", mk_key(10, 0, 0, 0, 0), 1, 7, 0, 0, 3);
        run_walk("t1_hi", mk_key(20, 0, 0, 0, 0), 1, 7, 0, 0, 3);
        run_walk("t1_miss", mk_key(21, 0, 0, 0, 0), 0, 0, 0, 0, 3);

        // CUT on field 1: equal to threshold goes right
        clear_mem();
        nodes[0] = mk_node(NODE_CUT, 1, 100, 0, 1, 2, 0);
        nodes[1] = mk_node(NODE_LEAF, 0, 0, 16'hffff, 0, 0, 3);
        nodes[2] = mk_node(NODE_LEAF, 0, 0, 16'hffff, 0, 0, 9);
        run_walk("t2_left", mk_key(0, 50, 0, 0, 0), 1, 3, 0, 0, 5);
        run_walk("t2_bound", mk_key(0, 100, 0, 0, 0), 1, 9, 0, 0, 5);

        // PART: both subtrees match, lower rule wins
        build_part_tree();
        p0 = pushes; q0 = pops;
        run_walk("t3_part", mk_key(1, 2, 3, 4, 5), 1, 2, 0, 0, 9);
        check_eq("t3.pushes", pushes - p0, 1);
        check_eq("t3.pops", pops - q0, 1);
        check_eq("t3.empty_at_done", last_empty, 1);

        // Chain of three PARTs overflows a two-entry LIFO, then a clean walk
        clear_mem();
        nodes[0] = mk_node(NODE_PART, 0, 0, 0, 1, 10, 0);
        nodes[1] = mk_node(NODE_PART, 0, 0, 0, 2, 11, 0);
        nodes[2] = mk_node(NODE_PART, 0, 0, 0, 3, 12, 0);
        nodes[3] = mk_node(NODE_LEAF, 0, 0, 16'hffff, 0, 0, 1);
        run_walk("t4_ovf", mk_key(0, 0, 0, 0, 0), 0, 0, 1, 0, 7);
        nodes[0] = mk_node(NODE_LEAF, 0, 10, 20, 0, 0, 7);
        run_walk("t4_after", mk_key(15, 0, 0, 0, 0), 1, 7, 0, 0, 3);

        // Self-looping CUT runs out of steps
        clear_mem();
        nodes[0] = mk_node(NODE_CUT, 0, 5, 0, 0, 0, 0);
        run_walk("t5_tmo", mk_key(1, 0, 0, 0, 0), 0, 0, 0, 1, 2*MS + 1);
        nodes[0] = mk_node(NODE_LEAF, 0, 10, 20, 0, 0, 7);
        run_walk("t5_after", mk_key(12, 0, 0, 0, 0), 1, 7, 0, 0, 3);

        // Reset while waiting on the pop
        build_part_tree();
        @(negedge clk);
        req_valid = 1'b1;
        req_key   = mk_key(1, 0, 0, 0, 0);
        @(posedge clk);
        repeat (6) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
        check_eq("t6.in_popwait", dut.state_q, S_POPWAIT);
        reset = 1'b1;
        @(negedge clk);
        check_eq("t6.ready", req_ready, 1);
        check_eq("t6.valid", resp_valid, 0);
        check_eq("t6.rd_en", mem_rd_en, 0);
        reset = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        check_eq("t6.no_resp", seen, 0);
        run_walk("t6_after", mk_key(1, 2, 3, 4, 5), 1, 2, 0, 0, 9);

        // Random trees: internal nodes 0..7 point forward, 8..15 terminate
        for (int it = 0; it < 25; it++) begin
            clear_mem();
            for (int i = 0; i < 16; i++) begin
                node_type_e t;
                int a0, b0;
                t  = (i < 8) ? node_type_e'($urandom_range(3, 0))
                             : node_type_e'($urandom_range(3, 2));
                a0 = $urandom_range(31, 0);
                b0 = $urandom_range(31, a0 / 2);
                nodes[i] = mk_node(t, $urandom_range(4, 0), a0, b0,
                                   (i < 8) ? $urandom_range(15, i + 1) : 0,
                                   (i < 8) ? $urandom_range(15, i + 1) : 0,
                                   $urandom_range(50, 1));
            end
            key = mk_key($urandom_range(31, 0), $urandom_range(31, 0), $urandom_range(31, 0),
                         $urandom_range(31, 0), $urandom_range(31, 0));
            model(key, eh, er, eo, et, el);
            run_walk($sformatf("rnd%0d", it), key, eh, er, eo, et, el);
        end

        check_eq("protocol_viol", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
